router_param: RTL and testbench

- Parametrised successor of the 3-port byte router: one serial packet input demultiplexed to N_PORTS output FIFOs.
- Header byte = {length, address}; length payload bytes follow, then one parity byte (XOR of header and payload).
- Adds over the previous generation:
  - configurable width, port count and FIFO depth;
  - per-port read-timeout flush with a programmable TIMEOUT;
  - explicit drop of packets to a non-existent port, with an o_Drop pulse.
- Sits between a packet source and N_PORTS downstream readers in the NoC fabric.

---
 rtl/router_param.sv | 233 +++++++++++++++++++++++
 tb/tb_router_param.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/router_param.sv
// Parametrised byte router: one packet stream demultiplexed into N_PORTS circular FIFOs.
// Reads have one cycle of latency; o_Sig_Busy stalls the source in CHECK or while the target FIFO is full.

module router_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_vld,
  input  logic [W-1:0] wr_dat,
  input  logic         rd_en,
  input  logic         flush,
  output logic [W-1:0] rd_dat,
  output logic         not_empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_wr;
  logic         do_rd;

  assign not_empty = (wr_ptr != rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_wr     = wr_vld && !full && !flush;
  assign do_rd     = rd_en && not_empty && !flush;

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_dat;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      rd_dat <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
      // A flush discards everything queued, including a write arriving this cycle.
      if (flush) begin
        rd_ptr <= wr_ptr;
      end else if (do_rd) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        rd_dat <= mem[rd_ptr[AW-1:0]];
      end
    end
  end
endmodule

module router_param #(
  parameter int DATA_W     = 8,
  parameter int N_PORTS    = 3,
  parameter int ADDR_W     = 2,
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT    = 30
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_Valid_Packet,
  input  logic [DATA_W-1:0]         i_Input_Data,
  input  logic [N_PORTS-1:0]        i_Sig_Read_Enable,
  output logic [N_PORTS*DATA_W-1:0] o_Output_Data,
  output logic [N_PORTS-1:0]        o_Output_Valid_Data,
  output logic                      o_Error,
  output logic                      o_Drop,
  output logic                      o_Sig_Busy
);
  localparam int LEN_W = DATA_W - ADDR_W;
  localparam int NA    = 1 << ADDR_W;
  localparam int TW    = $clog2(TIMEOUT + 1);

  localparam logic [ADDR_W:0] NP      = (ADDR_W+1)'(N_PORTS);
  localparam logic [LEN_W:0]  REM_ONE = (LEN_W+1)'(1);
  localparam logic [LEN_W:0]  REM_TWO = (LEN_W+1)'(2);
  localparam logic [TW-1:0]   T_LAST  = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0]   CNT_ONE = TW'(1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DATA   = 3'd1;
  localparam logic [2:0] S_PARITY = 3'd2;
  localparam logic [2:0] S_CHECK  = 3'd3;
  localparam logic [2:0] S_DROP   = 3'd4;

  typedef struct packed {
    logic [LEN_W-1:0]  len;
    logic [ADDR_W-1:0] addr;
  } hdr_t;

  logic [2:0]        state;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W:0]    rem_q;
  logic [DATA_W-1:0] par_q;
  logic [DATA_W-1:0] par_byte_q;

  hdr_t               hdr;
  logic               hdr_ok;
  logic [NA-1:0]      full_pad;
  logic [NA-1:0]      flush_pad;
  logic [N_PORTS-1:0] full;
  logic [N_PORTS-1:0] flush;
  logic [N_PORTS-1:0] wr_vld;
  logic               busy;
  logic               accept;
  logic               wr_any;
  logic [ADDR_W-1:0]  wr_addr;

  assign hdr    = hdr_t'(i_Input_Data);
  assign hdr_ok = ({1'b0, hdr.addr} < NP);

  // Pad per-port flags out to the full address space so unmapped addresses read as zero.
  always_comb begin
    full_pad                 = '0;
    full_pad[N_PORTS-1:0]    = full;
    flush_pad                = '0;
    flush_pad[N_PORTS-1:0]   = flush;
  end

  always_comb begin
    busy = 1'b0;
    case (state)
      S_CHECK:          busy = 1'b1;
      S_DATA, S_PARITY: busy = full_pad[addr_q];
      S_IDLE:           busy = i_Valid_Packet && hdr_ok && full_pad[hdr.addr];
      default:          busy = 1'b0;
    endcase
  end

  assign o_Sig_Busy = busy;
  assign accept  = !busy && ((state == S_IDLE && i_Valid_Packet) || state == S_DATA ||
                             state == S_PARITY || state == S_DROP);
  assign wr_addr = (state == S_IDLE) ? hdr.addr : addr_q;
  assign wr_any  = accept && (state == S_DATA || state == S_PARITY || (state == S_IDLE && hdr_ok));

  // rem_q counts the bytes still owed by the source, parity byte included.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      par_q      <= '0;
      par_byte_q <= '0;
      o_Error    <= 1'b0;
      o_Drop     <= 1'b0;
    end else begin
      o_Drop <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            addr_q  <= hdr.addr;
            rem_q   <= {1'b0, hdr.len} + REM_ONE;
            par_q   <= i_Input_Data;
            o_Error <= 1'b0;
            if (!hdr_ok || flush_pad[hdr.addr]) state <= S_DROP;
            else if (hdr.len == '0)             state <= S_PARITY;
            else                                state <= S_DATA;
          end
        end
        S_DATA: begin
          if (accept) begin
            par_q <= par_q ^ i_Input_Data;
            rem_q <= rem_q - REM_ONE;
          end
          if (flush_pad[addr_q])            state <= S_DROP;
          else if (accept && rem_q == REM_TWO) state <= S_PARITY;
        end
        S_PARITY: begin
          if (flush_pad[addr_q]) begin
            if (accept) begin
              o_Drop <= 1'b1;
              state  <= S_IDLE;
            end else begin
              state  <= S_DROP;
            end
          end else if (accept) begin
            par_byte_q <= i_Input_Data;
            state      <= S_CHECK;
          end
        end
        S_CHECK: begin
          o_Error <= (par_byte_q != par_q);
          state   <= S_IDLE;
        end
        S_DROP: begin
          if (accept) begin
            rem_q <= rem_q - REM_ONE;
            if (rem_q == REM_ONE) begin
              o_Drop <= 1'b1;
              state  <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < N_PORTS; k++) begin : g_port
    logic [DATA_W-1:0] rd_dat;
    logic              vld;
    logic [TW-1:0]     idle_cnt;

    assign wr_vld[k] = wr_any && (wr_addr == ADDR_W'(k));
    assign flush[k]  = vld && !i_Sig_Read_Enable[k] && (idle_cnt == T_LAST);

    always_ff @(posedge clk or negedge reset) begin
      if (!reset)                                    idle_cnt <= '0;
      else if (!vld || i_Sig_Read_Enable[k] || flush[k]) idle_cnt <= '0;
      else                                           idle_cnt <= idle_cnt + CNT_ONE;
    end

    router_fifo #(
      .W     (DATA_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .wr_vld    (wr_vld[k]),
      .wr_dat    (i_Input_Data),
      .rd_en     (i_Sig_Read_Enable[k]),
      .flush     (flush[k]),
      .rd_dat    (rd_dat),
      .not_empty (vld),
      .full      (full[k])
    );

    assign o_Output_Data[k*DATA_W +: DATA_W] = rd_dat;
    assign o_Output_Valid_Data[k]            = vld;
  end
endmodule

// File: tb/tb_router_param.sv
// Randomised packet traffic against a queue-based model of the router's packet and timeout rules.
module tb_router_param;
  localparam int DATA_W     = 8;
  localparam int N_PORTS    = 3;
  localparam int ADDR_W     = 2;
  localparam int FIFO_DEPTH = 16;
  localparam int TIMEOUT    = 30;

  logic                      clk = 1'b0;
  logic                      reset = 1'b0;
  logic                      i_Valid_Packet = 1'b0;
  logic [DATA_W-1:0]         i_Input_Data = '0;
  logic [N_PORTS-1:0]        i_Sig_Read_Enable = '0;
  logic [N_PORTS*DATA_W-1:0] o_Output_Data;
  logic [N_PORTS-1:0]        o_Output_Valid_Data;
  logic                      o_Error;
  logic                      o_Drop;
  logic                      o_Sig_Busy;

  router_param #(
    .DATA_W     (DATA_W),
    .N_PORTS    (N_PORTS),
    .ADDR_W     (ADDR_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .i_Valid_Packet      (i_Valid_Packet),
    .i_Input_Data        (i_Input_Data),
    .i_Sig_Read_Enable   (i_Sig_Read_Enable),
    .o_Output_Data       (o_Output_Data),
    .o_Output_Valid_Data (o_Output_Valid_Data),
    .o_Error             (o_Error),
    .o_Drop              (o_Drop),
    .o_Sig_Busy          (o_Sig_Busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: byte queues per port plus packet progress counters.
  logic [7:0] m_q [N_PORTS][$];
  logic [7:0] m_dat [N_PORTS];
  int         m_cnt [N_PORTS];
  bit         m_err, m_drop, m_check, m_in_pkt, m_dropping;
  int         m_port, m_rem;
  logic [7:0] m_par, m_pbyte;

  logic [7:0] src [$];
  int         gap;

  task automatic m_reset();
    for (int k = 0; k < N_PORTS; k++) begin
      m_q[k].delete();
      m_dat[k] = '0;
      m_cnt[k] = 0;
    end
    m_err = 0; m_drop = 0; m_check = 0; m_in_pkt = 0; m_dropping = 0;
    m_port = 0; m_rem = 0; m_par = '0; m_pbyte = '0;
  endtask

  function automatic bit m_busy(input bit vin, input logic [7:0] din);
    int a;
    a = int'(din) % (1 << ADDR_W);
    if (m_check) return 1'b1;
    if (m_in_pkt) return !m_dropping && (m_q[m_port].size() == FIFO_DEPTH);
    if (vin && a < N_PORTS) return m_q[a].size() == FIFO_DEPTH;
    return 1'b0;
  endfunction

  task automatic m_step(input bit vin, input logic [7:0] din, input logic [N_PORTS-1:0] rd,
                        output bit acc);
    bit fl [N_PORTS];
    int sz [N_PORTS];
    int a;
    acc = !m_busy(vin, din) && (m_in_pkt || vin);
    for (int k = 0; k < N_PORTS; k++) begin
      sz[k] = m_q[k].size();
      fl[k] = (sz[k] > 0) && !rd[k] && (m_cnt[k] == TIMEOUT - 1);
      if (rd[k] && sz[k] > 0) m_dat[k] = m_q[k].pop_front();
      m_cnt[k] = (sz[k] == 0 || rd[k] || fl[k]) ? 0 : m_cnt[k] + 1;
    end
    m_drop = 0;
    if (m_check) begin
      m_err   = (m_pbyte != m_par);
      m_check = 0;
    end
    if (acc && !m_in_pkt) begin
      a = int'(din) % (1 << ADDR_W);
      m_err = 0; m_par = din; m_rem = (int'(din) >> ADDR_W) + 1;
      m_in_pkt = 1; m_port = a;
      m_dropping = (a >= N_PORTS) ? 1'b1 : fl[a];
      if (!m_dropping) m_q[a].push_back(din);
    end else if (acc && m_dropping) begin
      m_rem--;
      if (m_rem == 0) begin m_drop = 1; m_in_pkt = 0; end
    end else if (acc) begin
      m_rem--;
      if (m_rem == 0) begin
        m_in_pkt = 0;
        if (fl[m_port]) m_drop = 1;
        else begin m_q[m_port].push_back(din); m_pbyte = din; m_check = 1; end
      end else begin
        m_par ^= din;
        if (fl[m_port]) m_dropping = 1;
        else m_q[m_port].push_back(din);
      end
    end else if (m_in_pkt && !m_dropping && fl[m_port]) begin
      m_dropping = 1;
    end
    for (int k = 0; k < N_PORTS; k++) if (fl[k]) m_q[k].delete();
  endtask

  task automatic check_outputs();
    for (int k = 0; k < N_PORTS; k++) begin
      chk($sformatf("valid%0d", k), 32'(o_Output_Valid_Data[k]), 32'(m_q[k].size() != 0));
      chk($sformatf("data%0d", k), 32'(o_Output_Data[k*DATA_W +: DATA_W]), 32'(m_dat[k]));
    end
    chk("error", 32'(o_Error), 32'(m_err));
    chk("drop", 32'(o_Drop), 32'(m_drop));
  endtask

  task automatic new_packet();
    int a, ln;
    logic [7:0] b, p;
    a  = $urandom_range(0, 3);
    ln = ($urandom_range(0, 6) == 0) ? 20 : $urandom_range(0, 9);
    b  = 8'((ln << ADDR_W) | a);
    p  = b;
    src.push_back(b);
    for (int i = 0; i < ln; i++) begin
      b = 8'($urandom);
      p ^= b;
      src.push_back(b);
    end
    src.push_back(($urandom_range(0, 3) == 0) ? (p ^ 8'h01) : p);
  endtask

  task automatic run_cycle(input int rd_pct);
    logic [N_PORTS-1:0] rd;
    bit vin, acc;
    logic [7:0] din;
    @(negedge clk);
    check_outputs();
    if (src.size() == 0) begin
      if (gap == 0) begin new_packet(); gap = $urandom_range(0, 3); end
      else gap--;
    end
    if (src.size() > 0) begin vin = (src.size() > 1); din = src[0]; end
    else begin vin = 1'b0; din = 8'($urandom); end
    for (int k = 0; k < N_PORTS; k++) rd[k] = ($urandom_range(0, 99) < rd_pct);
    i_Valid_Packet = vin; i_Input_Data = din; i_Sig_Read_Enable = rd;
    #1;
    chk("busy", 32'(o_Sig_Busy), 32'(m_busy(vin, din)));
    m_step(vin, din, rd, acc);
    if (acc) src.delete(0);
  endtask

  initial begin
    bit in_data;
    m_reset();
    gap = 0;
    #12;
    check_outputs();
    chk("busy_rst", 32'(o_Sig_Busy), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 400; i++) run_cycle(70);
    for (int i = 0; i < 200; i++) run_cycle(0);
    for (int i = 0; i < 300; i++) run_cycle(20);

    // Drive until the model sits mid-payload, then pull reset between clock edges.
    in_data = 0;
    for (int i = 0; i < 500 && !in_data; i++) begin
      run_cycle(60);
      in_data = m_in_pkt && !m_dropping && (m_rem > 1);
    end
    chk("reached_data", 32'(in_data), 32'd1);
    @(posedge clk);
    #2;
    i_Valid_Packet = 1'b0;
    i_Sig_Read_Enable = '0;
    reset = 1'b0;
    #1;
    m_reset();
    src.delete();
    gap = 0;
    check_outputs();
    chk("busy_midrst", 32'(o_Sig_Busy), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 300; i++) run_cycle(60);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
